decrypt_pipe_shift_unscramble: RTL

- Decrypt-side counterpart of the encrypt shift stages. Takes a ciphertext byte stream and removes the alphabetic Caesar shift applied on the encrypt side.
- Shift amount comes from a rotating key schedule (k1 -> k2 -> k3).
- Two-stage pipeline:
  - stage 1 classifies the byte and selects the key;
  - stage 2 performs the modulo-26 subtraction.
- Sits at the front of the decrypt pipe. Consumes bytes qualified by en and drives en_out/dout to the next decrypt stage.

---
 rtl/decrypt_pipe_shift_unscramble_if.sv | 28 ++
 rtl/decrypt_pipe_shift_unscramble.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decrypt_pipe_shift_unscramble_if.sv
// Byte-stream and key-configuration bundle for the decrypt unshift stage.
// The slave side is the unshift block; the master side feeds it bytes and keys.
interface decrypt_pipe_shift_unscramble_if #(
  parameter int ROT_W = 3
);
  logic             en;
  logic [7:0]       din;
  logic             shift_en;
  logic [7:0]       k1;
  logic [7:0]       k2;
  logic [7:0]       k3;
  logic [ROT_W-1:0] rot_freq;
  logic             key_load;
  logic             en_out;
  logic [7:0]       dout;
  logic             is_alpha_upper_case_out;
  logic             is_alpha_low_case_out;

  modport slave (
    input  en, din, shift_en, k1, k2, k3, rot_freq, key_load,
    output en_out, dout, is_alpha_upper_case_out, is_alpha_low_case_out
  );

  modport master (
    output en, din, shift_en, k1, k2, k3, rot_freq, key_load,
    input  en_out, dout, is_alpha_upper_case_out, is_alpha_low_case_out
  );
endinterface

// File: rtl/decrypt_pipe_shift_unscramble.sv
// Decrypt-side Caesar unshift. Stage 1 classifies the byte and picks the key
// from a rotating k1->k2->k3 schedule; stage 2 subtracts the key modulo 26.
module decrypt_pipe_shift_unscramble #(
  parameter int ROT_W   = 3,
  parameter int ALPHA_N = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  decrypt_pipe_shift_unscramble_if.slave bus
);

  typedef enum logic [1:0] {SEL_K1, SEL_K2, SEL_K3} sel_e;

  // Keys are reduced at capture so the datapath only handles 0..25.
  function automatic logic [4:0] red_alpha(input logic [7:0] k);
    return 5'(k % 8'(ALPHA_N));
  endfunction

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= 8'h61) && (b <= 8'h7A);
  endfunction

  // Modulo-26 subtraction inside one letter range starting at base.
  function automatic logic [7:0] unshift(input logic [7:0] b,
                                         input logic [7:0] base,
                                         input logic [4:0] s);
    logic [4:0]        idx;
    logic signed [6:0] r;
    idx = 5'(b - base);
    r   = $signed({2'b00, idx}) - $signed({2'b00, s});
    if (r < 0) r = r + $signed(7'(ALPHA_N));
    return base + {3'b000, r[4:0]};
  endfunction

  logic [4:0]       s1_q, s2_q, s3_q;
  logic [ROT_W-1:0] rot_q;
  sel_e             sel_q, sel_d;
  logic [ROT_W-1:0] cnt_q, cnt_d;

  sel_e             base_sel;
  logic [ROT_W-1:0] base_cnt;
  logic [ROT_W-1:0] base_rot;
  logic [4:0]       s_cur;
  logic             alpha_in;
  logic             adv;

  logic             vld_p1_q;
  logic [7:0]       din_p1_q;
  logic             up_p1_q;
  logic             lo_p1_q;
  logic             sh_p1_q;
  logic [4:0]       s_p1_q;

  logic [7:0]       dout_d;
  logic             en_out_q;
  logic [7:0]       dout_q;
  logic             up_p2_q;
  logic             lo_p2_q;

  assign alpha_in = is_upper(bus.din) || is_lower(bus.din);
  assign adv      = bus.en && bus.shift_en && alpha_in;

  // Capture reduced keys and rotation period on key_load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      rot_q <= '0;
    end else if (bus.key_load) begin
      s1_q  <= red_alpha(bus.k1);
      s2_q  <= red_alpha(bus.k2);
      s3_q  <= red_alpha(bus.k3);
      rot_q <= bus.rot_freq;
    end
  end

  // Key schedule state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_K1;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // Next schedule state: key_load restarts the schedule first, then the
  // current byte (if alpha and shifting) may advance it.
  always_comb begin
    base_sel = sel_q;
    base_cnt = cnt_q;
    base_rot = rot_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    s_cur    = s1_q;
    if (bus.key_load) begin
      base_sel = SEL_K1;
      base_cnt = '0;
      base_rot = bus.rot_freq;
      sel_d    = SEL_K1;
      cnt_d    = '0;
    end
    if (adv) begin
      if ((base_rot != '0) && (base_cnt == base_rot - ROT_W'(1))) begin
        cnt_d = '0;
        case (base_sel)
          SEL_K1:  sel_d = SEL_K2;
          SEL_K2:  sel_d = SEL_K3;
          default: sel_d = SEL_K1;
        endcase
      end else begin
        cnt_d = base_cnt + ROT_W'(1);
      end
    end
    if (bus.key_load) begin
      s_cur = red_alpha(bus.k1);
    end else begin
      case (sel_q)
        SEL_K1:  s_cur = s1_q;
        SEL_K2:  s_cur = s2_q;
        default: s_cur = s3_q;
      endcase
    end
  end

  // Stage 1: register byte, class, shift enable and selected key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      din_p1_q <= '0;
      up_p1_q  <= 1'b0;
      lo_p1_q  <= 1'b0;
      sh_p1_q  <= 1'b0;
      s_p1_q   <= '0;
    end else begin
      vld_p1_q <= bus.en;
      if (bus.en) begin
        din_p1_q <= bus.din;
        up_p1_q  <= is_upper(bus.din);
        lo_p1_q  <= is_lower(bus.din);
        sh_p1_q  <= bus.shift_en;
        s_p1_q   <= s_cur;
      end
    end
  end

  // Stage 2 datapath: unshift within the byte's own letter range.
  always_comb begin
    dout_d = din_p1_q;
    if (sh_p1_q && up_p1_q) begin
      dout_d = unshift(din_p1_q, 8'h41, s_p1_q);
    end else if (sh_p1_q && lo_p1_q) begin
      dout_d = unshift(din_p1_q, 8'h61, s_p1_q);
    end
  end

  // Stage 2: output register; data and flags hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_q <= 1'b0;
      dout_q   <= '0;
      up_p2_q  <= 1'b0;
      lo_p2_q  <= 1'b0;
    end else begin
      en_out_q <= vld_p1_q;
      if (vld_p1_q) begin
        dout_q  <= dout_d;
        up_p2_q <= up_p1_q;
        lo_p2_q <= lo_p1_q;
      end
    end
  end

  assign bus.en_out                  = en_out_q;
  assign bus.dout                    = dout_q;
  assign bus.is_alpha_upper_case_out = up_p2_q;
  assign bus.is_alpha_low_case_out   = lo_p2_q;

endmodule
